// File: rtl/int_ctrl_mc_if.sv
// int_ctrl_mc_if: event inputs, register controls and pin outputs of the multi-channel interrupt controller.
interface int_ctrl_mc_if #(
    parameter int NW    = 11,
    parameter int NO    = 2,
    parameter int CNT_W = 4
);
    logic [NW-1:0]    int_flag_in;
    logic [NW-1:0]    rg_int_enable;
    logic [NW-1:0]    rg_int_clr;
    logic [NW*NO-1:0] rg_int_route;
    logic [NO-1:0]    rg_int_low_en;
    logic [NO-1:0]    rg_int_level_en;
    logic [10:0]      rg_int_width;
    logic [5:0]       rg_cold_time;
    logic [CNT_W-1:0] rg_coal_thr;
    logic             rg_int_after_frame;
    logic             frame_on;
    logic             rg_timer_on;
    logic             rg_timer_mode;
    logic [8:0]       rg_timer_sel;
    logic [NW-1:0]    int_status;
    logic [NO-1:0]    int_pending;
    logic [NO-1:0]    int_out;

    modport master (
        output int_flag_in, rg_int_enable, rg_int_clr, rg_int_route, rg_int_low_en,
               rg_int_level_en, rg_int_width, rg_cold_time, rg_coal_thr,
               rg_int_after_frame, frame_on, rg_timer_on, rg_timer_mode, rg_timer_sel,
        input  int_status, int_pending, int_out
    );
    modport slave (
        input  int_flag_in, rg_int_enable, rg_int_clr, rg_int_route, rg_int_low_en,
               rg_int_level_en, rg_int_width, rg_cold_time, rg_coal_thr,
               rg_int_after_frame, frame_on, rg_timer_on, rg_timer_mode, rg_timer_sel,
        output int_status, int_pending, int_out
    );
endinterface

// File: rtl/int_ctrl_mc.sv
// int_ctrl_mc: sticky event status routed to NO coalescing pulse/level/cold-time interrupt pins.
// Define INT_CTRL_TIMER_EN to add the periodic timer that injects events on source NW-1.
module int_ctrl_mc #(
    parameter int NW    = 11,
    parameter int NO    = 2,
    parameter int CNT_W = 4
) (
    input logic           clk_32k,
    input logic           rst,
    int_ctrl_mc_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ASSERT, COLD} state_t;

    logic [NW-1:0] flag_d1;
    logic [NW-1:0] ev;
    logic [NW-1:0] status;
    logic [NO-1:0] pending;
    logic [NO-1:0] out;
    logic          timer_ev;

`ifdef INT_CTRL_TIMER_EN
    logic [21:0] tmr;
    logic [21:0] tmr_last;
    logic        tmr_done;
    assign tmr_last = 22'(({13'd0, bus.rg_timer_sel} + 22'd1) * 22'd6554 - 22'd1);
    assign timer_ev = bus.rg_timer_on && !tmr_done && tmr == tmr_last;
    always_ff @(posedge clk_32k) begin
        if (rst || !bus.rg_timer_on) begin
            tmr      <= '0;
            tmr_done <= 1'b0;
        end else if (!tmr_done) begin
            tmr      <= timer_ev ? '0 : tmr + 22'd1;
            tmr_done <= timer_ev && !bus.rg_timer_mode;
        end
    end
`else
    assign timer_ev = 1'b0;
`endif

    assign ev = (bus.int_flag_in & ~flag_d1 & bus.rg_int_enable) | {timer_ev, {(NW-1){1'b0}}};

    always_ff @(posedge clk_32k) begin
        if (rst) begin
            flag_d1 <= '0;
            status  <= '0;
        end else begin
            flag_d1 <= bus.int_flag_in;
            status  <= (status & ~bus.rg_int_clr) | ev;
        end
    end

    for (genvar j = 0; j < NO; j++) begin : g_pin
        logic [NW-1:0]    route;
        logic             pin_ev;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] thr;
        logic [CNT_W:0]   sum;
        logic             trig;
        logic [10:0]      tcnt;
        logic             tend;
        state_t           state;
        state_t           nxt;
        state_t           start;
        assign route      = bus.rg_int_route[j*NW +: NW];
        assign pin_ev     = |(ev & route);
        assign pending[j] = |(status & route);
        assign thr        = bus.rg_coal_thr == '0 ? {{(CNT_W-1){1'b0}}, 1'b1} : bus.rg_coal_thr;
        assign sum        = {1'b0, cnt} + {{CNT_W{1'b0}}, pin_ev};
        assign trig       = sum >= {1'b0, thr};
        assign start      = bus.rg_int_after_frame && bus.frame_on ? WAIT_FRAME : ASSERT;
        // >= so a level-to-pulse switch mid-assert with tcnt already past W still ends
        assign tend       = state == ASSERT ? tcnt >= bus.rg_int_width : tcnt == {bus.rg_cold_time, 5'h1f};
        assign out[j]     = (state == ASSERT) ^ bus.rg_int_low_en[j];

        always_comb begin
            nxt = state;
            case (state)
                IDLE:       nxt = trig ? start : IDLE;
                WAIT_FRAME: nxt = bus.frame_on ? WAIT_FRAME : ASSERT;
                ASSERT:     nxt = (bus.rg_int_level_en[j] ? !pending[j] : tend) ? COLD : ASSERT;
                COLD:       nxt = tend ? (trig ? start : IDLE) : COLD;
                default:    nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk_32k) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
                tcnt  <= '0;
            end else begin
                state <= nxt;
                tcnt  <= nxt != state ? '0 : tcnt + 11'd1;
                cnt   <= nxt == ASSERT && state != ASSERT ? '0 : (pin_ev && !(&cnt)) ? cnt + 1'b1 : cnt;
            end
        end
    end

    assign bus.int_status  = status;
    assign bus.int_pending = pending;
    assign bus.int_out     = out;
endmodule

// File: tb/tb_int_ctrl_mc.sv
// tb_int_ctrl_mc: table-driven directed vectors plus hand sequences for cold time, coalescing, frame deferral and reset.
module tb_int_ctrl_mc;
    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;

    int_ctrl_mc_if #(.NW(11), .NO(2), .CNT_W(4)) bus ();
    int_ctrl_mc #(.NW(11), .NO(2), .CNT_W(4)) dut (.clk_32k(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [10:0] flag;
        logic [10:0] clr;
        logic        frame;
        logic [10:0] st;
        logic [1:0]  pend;
        logic [1:0]  out;
    } vec_t;
    vec_t vecs[29];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            bus.int_flag_in = vecs[k].flag;
            bus.rg_int_clr  = vecs[k].clr;
            bus.frame_on    = vecs[k].frame;
            step();
            chk($sformatf("vec%0d status", k), 32'(bus.int_status), 32'(vecs[k].st));
            chk($sformatf("vec%0d pending", k), 32'(bus.int_pending), 32'(vecs[k].pend));
            chk($sformatf("vec%0d out", k), 32'(bus.int_out), 32'(vecs[k].out));
        end
        bus.rg_int_clr = '0;
    endtask

    task automatic flush(input int n);
        bus.int_flag_in = '0;
        bus.rg_int_clr  = '1;
        step();
        bus.rg_int_clr = '0;
        repeat (n) step();
    endtask

    initial begin
        // pulse, W=3, C=0, source 3 -> pin 0
        vecs[0]  = '{11'h008, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[1]  = '{11'h008, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[2]  = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[3]  = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[4]  = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b10};
        vecs[5]  = '{11'h000, 11'h008, 1'b0, 11'h000, 2'b00, 2'b10};
        vecs[6]  = '{11'h000, 11'h000, 1'b0, 11'h000, 2'b00, 2'b10};
        // level mode on pin 0, clear 5 cycles after the event
        vecs[7]  = '{11'h008, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[8]  = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[9]  = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[10] = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[11] = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[12] = '{11'h000, 11'h008, 1'b0, 11'h000, 2'b00, 2'b11};
        vecs[13] = '{11'h000, 11'h000, 1'b0, 11'h000, 2'b00, 2'b10};
        vecs[14] = '{11'h008, 11'h000, 1'b0, 11'h008, 2'b01, 2'b10};
        // coalescing threshold 3, sources 3 and 5 -> pin 0, W=0
        vecs[15] = '{11'h008, 11'h000, 1'b0, 11'h008, 2'b01, 2'b10};
        vecs[16] = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b10};
        vecs[17] = '{11'h020, 11'h000, 1'b0, 11'h028, 2'b01, 2'b10};
        vecs[18] = '{11'h000, 11'h000, 1'b0, 11'h028, 2'b01, 2'b10};
        vecs[19] = '{11'h008, 11'h000, 1'b0, 11'h028, 2'b01, 2'b11};
        vecs[20] = '{11'h000, 11'h000, 1'b0, 11'h028, 2'b01, 2'b10};
        // assertion deferred until frame_on falls
        vecs[21] = '{11'h008, 11'h000, 1'b1, 11'h008, 2'b01, 2'b10};
        vecs[22] = '{11'h000, 11'h000, 1'b1, 11'h008, 2'b01, 2'b10};
        vecs[23] = '{11'h000, 11'h000, 1'b1, 11'h008, 2'b01, 2'b10};
        vecs[24] = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[25] = '{11'h000, 11'h000, 1'b0, 11'h008, 2'b01, 2'b10};
        // set wins over clear; source 0 -> active-low pin 1
        vecs[26] = '{11'h008, 11'h008, 1'b0, 11'h008, 2'b01, 2'b11};
        vecs[27] = '{11'h001, 11'h000, 1'b0, 11'h009, 2'b11, 2'b00};
        vecs[28] = '{11'h000, 11'h000, 1'b0, 11'h009, 2'b11, 2'b10};

        rst                    = 1'b1;
        bus.int_flag_in        = '0;
        bus.rg_int_enable      = '1;
        bus.rg_int_clr         = '0;
        bus.rg_int_route       = 22'h000008;
        bus.rg_int_low_en      = 2'b10;
        bus.rg_int_level_en    = 2'b00;
        bus.rg_int_width       = 11'd3;
        bus.rg_cold_time       = 6'd0;
        bus.rg_coal_thr        = 4'd0;
        bus.rg_int_after_frame = 1'b0;
        bus.frame_on           = 1'b0;
        bus.rg_timer_on        = 1'b0;
        bus.rg_timer_mode      = 1'b0;
        bus.rg_timer_sel       = 9'd0;
        step();
        step();
        chk("reset out", 32'(bus.int_out), 32'h2);
        chk("reset status", 32'(bus.int_status), 32'h0);
        chk("reset pending", 32'(bus.int_pending), 32'h0);
        rst = 1'b0;

        run(0, 6);
        flush(40);

        bus.rg_int_level_en = 2'b01;
        run(7, 14);
        bus.int_flag_in = '0;
        for (int k = 0; k < 30; k++) begin
            step();
            chk($sformatf("cold hold %0d", k), 32'(bus.int_out), 32'h2);
        end
        step();
        chk("cold release", 32'(bus.int_out), 32'h3);
        flush(40);

        bus.rg_int_level_en = 2'b00;
        bus.rg_int_width    = 11'd0;
        bus.rg_coal_thr     = 4'd3;
        bus.rg_int_route    = 22'h000028;
        run(15, 20);
        repeat (34) step();
        bus.int_flag_in = 11'h020;
        step();
        chk("coal count cleared", 32'(bus.int_out), 32'h2);
        bus.int_flag_in = '0;
        repeat (3) step();
        chk("coal still idle", 32'(bus.int_out), 32'h2);
        bus.rg_coal_thr = 4'd0;
        step();
        chk("thr 0 fires on count 1", 32'(bus.int_out), 32'h3);
        flush(40);

        bus.rg_int_route       = 22'h000008;
        bus.rg_int_after_frame = 1'b1;
        run(21, 25);
        bus.rg_int_after_frame = 1'b0;
        flush(40);

        bus.rg_int_route = 22'h000808;
        run(26, 28);
        bus.rg_int_enable = 11'h7f7;
        step();
        chk("disable keeps status", 32'(bus.int_status), 32'h009);
        bus.rg_int_clr = '1;
        step();
        bus.rg_int_clr = '0;
        chk("clear all", 32'(bus.int_status), 32'h000);
        bus.int_flag_in = 11'h008;
        step();
        chk("disabled source", 32'(bus.int_status), 32'h000);
        bus.int_flag_in   = '0;
        bus.rg_int_enable = '1;
        repeat (40) step();

        bus.rg_int_route    = 22'h000008;
        bus.rg_int_level_en = 2'b01;
        bus.int_flag_in     = 11'h008;
        step();
        chk("level assert", 32'(bus.int_out), 32'h3);
        rst = 1'b1;
        step();
        chk("reset abort out", 32'(bus.int_out), 32'h2);
        chk("reset abort status", 32'(bus.int_status), 32'h0);
        rst             = 1'b0;
        bus.int_flag_in = '0;
        step();
        chk("after reset idle", 32'(bus.int_out), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/int_ctrl_mc.md
# int_ctrl_mc

Multi-channel interrupt controller for the always-on domain, generalising the single-pin interrupt controller. NW event sources are latched into a sticky status vector, routed through a per-pin mask to NO independent interrupt pins, and each pin is driven by its own pulse/level/cold-time state machine with event coalescing. It sits between the sensing/FIFO/power event generators and the host INT pads, clocked by the 32 kHz clock.

## Interface
- NW, 11, number of event sources
- NO, 2, number of interrupt output pins
- CNT_W, 4, coalescing counter width
- clk_32k  in  1  32.768 kHz clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- int_flag_in  in  NW  raw event sources; an event is a 0->1 transition
- rg_int_enable  in  NW  per-source latch enable
- rg_int_clr  in  NW  write-1 clear of int_status, one-cycle pulse
- rg_int_route  in  NW*NO  bit [j*NW+i] routes source i to pin j
- rg_int_low_en  in  NO  per-pin polarity: 0 active-high, 1 active-low
- rg_int_level_en  in  NO  per-pin mode: 0 pulse, 1 level
- rg_int_width  in  11  pulse width W; high time = W+1 cycles (1..2048)
- rg_cold_time  in  6  cold time C; (C+1)*32 cycles (about 1..64 ms)
- rg_coal_thr  in  CNT_W  events needed to fire a pin; 0 and 1 both mean immediate
- rg_int_after_frame  in  1  1: defer assertion until frame_on is low
- frame_on  in  1  sensing frame in progress
- rg_timer_on, rg_timer_mode, rg_timer_sel  in  1,1,9  periodic timer control (see Configuration)
- int_status  out  NW  sticky status, read-only
- int_pending  out  NO  pin j has at least one routed status bit set
- int_out  out  NO  interrupt pins, polarity applied

## Operation
- Edge detect: flag_d1 is registered; ev[i] = int_flag_in[i] & ~flag_d1[i] & rg_int_enable[i].
- Status: ev[i] sets int_status[i]; rg_int_clr[i] clears it. Simultaneous set and clear: set wins. Disabling a source does not clear its status.
- int_pending[j] = |(int_status & route_j). pin_ev[j] = |(ev & route_j).
- Coalescing counter per pin: +1 per cycle with pin_ev, saturating at all-ones; cleared on entering ASSERT. trig[j] = count + pin_ev >= max(rg_coal_thr, 1).
- Per-pin FSM states: IDLE, WAIT_FRAME, ASSERT, COLD.
  - IDLE: on trig, go to WAIT_FRAME if rg_int_after_frame & frame_on, else ASSERT.
  - WAIT_FRAME: go to ASSERT in the first cycle frame_on = 0.
  - ASSERT, pulse mode: width counter runs W+1 cycles, then COLD.
  - ASSERT, level mode: hold until int_pending[j] = 0, then COLD.
  - COLD: (C+1)*32 cycles, then IDLE. Events during COLD are counted, not lost. If trig holds at COLD exit, go directly to ASSERT or WAIT_FRAME.
- int_out[j] = (state == ASSERT) ^ rg_int_low_en[j].
- Register changes take effect immediately; a mode change during ASSERT applies from the next cycle.

## Timing
- Reset state: int_status = 0, int_pending = 0, counters = 0, all FSMs in IDLE, flag_d1 = 0, int_out = rg_int_low_en.
- int_flag_in rises at cycle N -> int_status and int_out change at edge N+1, in the same cycle.
- Pulse high time is exactly W+1 cycles. Cold time is exactly (C+1)*32 cycles.
- Clear at cycle N -> status 0 at N+1. In level mode, int_out deasserts at N+2.
- Reset asserted mid-operation aborts the FSM to IDLE at the next edge and drops in-flight events.

## Configuration
- INT_CTRL_TIMER_EN defined:
  - Periodic timer counts (rg_timer_sel+1)*6554 cycles while rg_timer_on = 1.
  - At expiry it injects an event on source NW-1, ORed with the edge detector.
  - Mode 0 fires once and stops. Mode 1 reloads and repeats.
  - rg_timer_on = 0 resets the timer counter.
- INT_CTRL_TIMER_EN undefined: no timer logic; the timer ports are present but ignored.

## Test plan
- Reset with rg_int_low_en = 2'b10 -> int_out = 2'b10, int_status = 0.
- Pulse on source 3, route to pin 0 only, W = 3 -> int_out[0] high for exactly 4 cycles starting 1 cycle after the event; int_status[3] = 1 until rg_int_clr = 11'h008.
- Level mode, C = 0: event, then clear 5 cycles later -> int_out deasserts 2 cycles after the clear; a new event in the next 32 cycles is held until cold time ends.
- rg_coal_thr = 3: three events on routed sources -> no assertion after events 1 and 2; assertion at event 3; counter reads 0 afterwards.
- rg_int_after_frame = 1, frame_on = 1 during event -> int_out stays idle; asserts 1 cycle after frame_on falls.
- Set and clear on the same source in the same cycle -> status = 1. With the timer enabled: rg_timer_sel = 0, mode 1 -> status[NW-1] sets every 6554 cycles.
